// File: rtl/uart_cfg.sv
// uart_cfg: configurable UART for the console/debug serial link.
// It supports 5..8 data bits, none/odd/even parity and 1 or 2 stop bits.
// RX samples each bit three times and takes a majority vote.
// Optional build macro UART_CFG_RX_FIFO_EN: received words are queued in an
// RX_FIFO_DEPTH-entry FIFO instead of a single holding register.
module uart_cfg #(
    parameter int FREQ_HZ       = 25000000,
    parameter int BAUD          = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_avail,
    input  logic                 rx_ack,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_busy
);
    localparam int          DIV        = FREQ_HZ / (BAUD * 16);
    localparam logic [15:0] DIV_RELOAD = 16'(DIV - 1);
    localparam int          FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

    // Parity bit that makes the total count of ones odd (PARITY=1) or even
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic [15:0] tick_cnt;
    logic        tick;
    assign tick = (tick_cnt == 16'd0);

    // Oversampling tick at 16x the line rate
    always_ff @(posedge clk) begin
        if (!reset)    tick_cnt <= DIV_RELOAD;
        else if (tick) tick_cnt <= DIV_RELOAD;
        else           tick_cnt <= tick_cnt - 16'd1;
    end

    logic rxd_meta, rxd_sync;

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    rx_state_t            rx_state;
    logic [3:0]           rx_phase;
    logic [2:0]           rx_bit_idx;
    logic [1:0]           rx_samp;
    logic                 rx_bit;
    logic                 rx_maj;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_perr;
    logic                 rx_line_wait;
    logic                 word_valid;
    logic                 frame_err_set;
    logic                 overrun_set;

    assign rx_maj = (rx_samp[0] & rx_samp[1]) | (rx_samp[0] & rxd_sync) | (rx_samp[1] & rxd_sync);

    // Receive FSM: phase 0 is the first low sample, bits are voted at phases 7..9
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state      <= RX_IDLE;
            rx_phase      <= 4'd0;
            rx_bit_idx    <= 3'd0;
            rx_samp       <= 2'b11;
            rx_bit        <= 1'b1;
            rx_shift      <= '0;
            rx_perr       <= 1'b0;
            rx_line_wait  <= 1'b0;
            word_valid    <= 1'b0;
            frame_err_set <= 1'b0;
        end else begin
            word_valid    <= 1'b0;
            frame_err_set <= 1'b0;
            if (tick) begin
                rx_phase <= rx_phase + 4'd1;
                if (rx_phase == 4'd7) rx_samp[0] <= rxd_sync;
                if (rx_phase == 4'd8) rx_samp[1] <= rxd_sync;
                if (rx_phase == 4'd9) rx_bit <= rx_maj;
                unique case (rx_state)
                    RX_IDLE: begin
                        if (!rxd_sync) begin
                            rx_phase <= 4'd1;
                            rx_state <= RX_START;
                        end else begin
                            rx_phase <= 4'd0;
                        end
                    end
                    RX_START: begin
                        if (rx_phase == 4'd15) begin
                            rx_bit_idx <= 3'd0;
                            rx_perr    <= 1'b0;
                            rx_state   <= rx_bit ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (rx_phase == 4'd15) begin
                            rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
                            if (rx_bit_idx == 3'(DATA_BITS - 1))
                                rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                            else
                                rx_bit_idx <= rx_bit_idx + 3'd1;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_phase == 4'd15) begin
                            rx_perr  <= (rx_bit != parity_of(rx_shift));
                            rx_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (rx_line_wait) begin
                            if (rxd_sync) begin
                                rx_line_wait <= 1'b0;
                                rx_phase     <= 4'd0;
                                rx_state     <= RX_IDLE;
                            end
                        end else if (rx_phase == 4'd9) begin
                            if (rx_maj) begin
                                word_valid <= 1'b1;
                                rx_phase   <= 4'd0;
                                rx_state   <= RX_IDLE;
                            end else begin
                                frame_err_set <= 1'b1;
                                rx_line_wait  <= 1'b1;
                            end
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

`ifdef UART_CFG_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    logic [DATA_BITS:0] fifo_mem [RX_FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full, do_push, do_pop;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop      = rx_ack && !fifo_empty;
    assign do_push     = word_valid && (!fifo_full || do_pop);
    assign overrun_set = word_valid && !do_push;
    assign rx_avail    = !fifo_empty;
    assign {rx_parity_err, rx_data} = fifo_mem[rd_ptr[AW-1:0]];

    // RX FIFO; a pop frees the head slot so a push on full can reuse it
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= {rx_perr, rx_shift};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
`else
    logic load_word;
    assign load_word   = word_valid && (!rx_avail || rx_ack);
    assign overrun_set = word_valid && !load_word;

    // Single holding register; an unacknowledged word is never overwritten
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_avail      <= 1'b0;
        end else if (load_word) begin
            rx_data       <= rx_shift;
            rx_parity_err <= rx_perr;
            rx_avail      <= 1'b1;
        end else if (rx_ack && rx_avail) begin
            rx_avail <= 1'b0;
        end
    end
`endif

    // Sticky error flags: a new error in the same cycle wins over rx_ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            if (frame_err_set) rx_frame_err <= 1'b1;
            else if (rx_ack)   rx_frame_err <= 1'b0;
            if (overrun_set)   rx_overrun <= 1'b1;
            else if (rx_ack)   rx_overrun <= 1'b0;
        end
    end

    typedef enum logic [1:0] {TX_IDLE, TX_ALIGN, TX_SEND} tx_state_t;
    tx_state_t             tx_state;
    logic [FRAME_BITS-2:0] tx_frame;
    logic [FRAME_BITS-2:0] tx_shift;
    logic [3:0]            tx_phase;
    logic [3:0]            tx_bits_left;

    // Everything after the start bit: data LSB first, optional parity, stop ones
    always_comb begin
        tx_frame = '1;
        tx_frame[DATA_BITS-1:0] = tx_data;
        if (PARITY != 0) tx_frame[DATA_BITS] = parity_of(tx_data);
    end

    // Transmit FSM; the start bit goes out at once and is timed from the next tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state     <= TX_IDLE;
            uart_txd     <= 1'b1;
            tx_busy      <= 1'b0;
            tx_shift     <= '1;
            tx_phase     <= 4'd0;
            tx_bits_left <= 4'd0;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (tx_wr) begin
                        tx_shift     <= tx_frame;
                        uart_txd     <= 1'b0;
                        tx_busy      <= 1'b1;
                        tx_bits_left <= 4'(FRAME_BITS - 1);
                        tx_state     <= TX_ALIGN;
                    end
                end
                TX_ALIGN: begin
                    if (tick) begin
                        tx_phase <= 4'd0;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tick) begin
                        if (tx_phase == 4'd15) begin
                            tx_phase <= 4'd0;
                            if (tx_bits_left == 4'd0) begin
                                uart_txd <= 1'b1;
                                tx_busy  <= 1'b0;
                                tx_state <= TX_IDLE;
                            end else begin
                                uart_txd     <= tx_shift[0];
                                tx_shift     <= tx_shift >> 1;
                                tx_bits_left <= tx_bits_left - 4'd1;
                            end
                        end else begin
                            tx_phase <= tx_phase + 4'd1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed bench for uart_cfg at 32 clocks per bit.
// Three instances: A = 8N1 (TX, RX, errors), B = 7E2 loopback, C = 8O1 RX parity.
// Honours UART_CFG_RX_FIFO_EN for the overrun expectations.
module tb_uart_cfg;
    localparam int FREQ    = 3686400;
    localparam int RATE    = 115200;
    localparam int BIT_CLK = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    logic rec [0:1023];

    logic       rxdA = 1'b1, txdA, availA, ackA = 1'b0, perrA, ferrA, ovrA, wrA = 1'b0, busyA;
    logic [7:0] rxDataA, txDataA = 8'h00;
    logic       txdB, availB, ackB = 1'b0, perrB, ferrB, ovrB, wrB = 1'b0, busyB;
    logic [6:0] rxDataB, txDataB = 7'h00;
    logic       rxdC = 1'b1, txdC, availC, ackC = 1'b0, perrC, ferrC, ovrC, wrC = 1'b0, busyC;
    logic [7:0] rxDataC, txDataC = 8'h00;

    uart_cfg #(.FREQ_HZ(FREQ), .BAUD(RATE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
        .clk(clk), .reset(reset), .uart_rxd(rxdA), .uart_txd(txdA), .rx_data(rxDataA),
        .rx_avail(availA), .rx_ack(ackA), .rx_parity_err(perrA), .rx_frame_err(ferrA),
        .rx_overrun(ovrA), .tx_data(txDataA), .tx_wr(wrA), .tx_busy(busyA));

    uart_cfg #(.FREQ_HZ(FREQ), .BAUD(RATE), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dutB (
        .clk(clk), .reset(reset), .uart_rxd(txdB), .uart_txd(txdB), .rx_data(rxDataB),
        .rx_avail(availB), .rx_ack(ackB), .rx_parity_err(perrB), .rx_frame_err(ferrB),
        .rx_overrun(ovrB), .tx_data(txDataB), .tx_wr(wrB), .tx_busy(busyB));

    uart_cfg #(.FREQ_HZ(FREQ), .BAUD(RATE), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutC (
        .clk(clk), .reset(reset), .uart_rxd(rxdC), .uart_txd(txdC), .rx_data(rxDataC),
        .rx_avail(availC), .rx_ack(ackC), .rx_parity_err(perrC), .rx_frame_err(ferrC),
        .rx_overrun(ovrC), .tx_data(txDataC), .tx_wr(wrC), .tx_busy(busyC));

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive a serial frame (bit 0 first) onto the RX line of A (which=0) or C (which=1)
    task automatic applyStimulus(input int which, input logic [11:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (which == 0) rxdA = bits[i];
            else            rxdC = bits[i];
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    // Pulse rx_ack for one cycle on A (0), B (1) or C (2)
    task automatic ackRx(input int which);
        if (which == 0) ackA = 1'b1;
        else if (which == 1) ackB = 1'b1;
        else ackC = 1'b1;
        @(negedge clk);
        ackA = 1'b0;
        ackB = 1'b0;
        ackC = 1'b0;
        @(negedge clk);
    endtask

    // Record the TX line every clock while busy; on A also strobe tx_wr mid-frame
    task automatic captureTx(input int which, output int n);
        n = 0;
        while (((which == 0) ? busyA : busyB) && n < 1000) begin
            rec[n] = (which == 0) ? txdA : txdB;
            if (which == 0 && n == 100) begin
                txDataA = 8'hFF;
                wrA = 1'b1;
            end
            if (which == 0 && n == 101) wrA = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    // Check each bit at its centre, counting back from the end of the last stop bit
    task automatic checkFrame(input string name, input int n, input logic [11:0] expBits, input int nbits);
        int idx;
        for (int k = 0; k < nbits; k++) begin
            idx = n - BIT_CLK * (nbits - k) + BIT_CLK / 2;
            if (idx < 0) idx = 0;
            checkOutput($sformatf("%s bit%0d", name, k), 32'(rec[idx]), 32'(expBits[k]));
        end
    endtask

    function automatic int clampTo(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        logic [11:0] expBits;

        repeat (5) @(negedge clk);
        checkOutput("reset txd", 32'(txdA), 32'd1);
        checkOutput("reset tx_busy", 32'(busyA), 32'd0);
        checkOutput("reset rx_avail", 32'(availA), 32'd0);
        checkOutput("reset rx_data", 32'(rxDataA), 32'h00);
        checkOutput("reset frame_err", 32'(ferrA), 32'd0);
        checkOutput("reset overrun", 32'(ovrA), 32'd0);
        checkOutput("reset parity_err", 32'(perrA), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 transmit of 0xA5, with an ignored write strobe mid-frame
        txDataA = 8'hA5;
        wrA = 1'b1;
        @(negedge clk);
        wrA = 1'b0;
        checkOutput("txA busy after wr", 32'(busyA), 32'd1);
        captureTx(0, n);
        checkOutput("txA frame done", 32'(busyA), 32'd0);
        checkOutput("txA busy length", n, clampTo(n, 320, 322));
        expBits = {2'b00, 1'b1, 8'hA5, 1'b0};
        checkFrame("txA", n, expBits, 10);
        checkOutput("txA idle high", 32'(txdA), 32'd1);
        repeat (40) @(negedge clk);
        checkOutput("txA no second frame", 32'(busyA), 32'd0);

        // Reset in the middle of a transmit
        txDataA = 8'h00;
        wrA = 1'b1;
        @(negedge clk);
        wrA = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("txA busy mid-frame", 32'(busyA), 32'd1);
        checkOutput("txA line low mid-frame", 32'(txdA), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset mid-tx txd", 32'(txdA), 32'd1);
        checkOutput("reset mid-tx busy", 32'(busyA), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Plain receive on A
        applyStimulus(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);
        repeat (4) @(negedge clk);
        checkOutput("rxA avail", 32'(availA), 32'd1);
        checkOutput("rxA data", 32'(rxDataA), 32'h3C);
        checkOutput("rxA parity_err", 32'(perrA), 32'd0);
        checkOutput("rxA frame_err", 32'(ferrA), 32'd0);
        ackRx(0);
        checkOutput("rxA avail after ack", 32'(availA), 32'd0);

        // Five frames with no acknowledge
        for (int i = 1; i <= 5; i++) applyStimulus(0, {2'b00, 1'b1, 8'(8'h11 * i), 1'b0}, 10);
        repeat (4) @(negedge clk);
        checkOutput("ovr overrun set", 32'(ovrA), 32'd1);
`ifdef UART_CFG_RX_FIFO_EN
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("fifo avail %0d", i), 32'(availA), 32'd1);
            checkOutput($sformatf("fifo data %0d", i), 32'(rxDataA), 32'(8'h11 * i));
            ackRx(0);
        end
`else
        checkOutput("hold avail", 32'(availA), 32'd1);
        checkOutput("hold keeps first", 32'(rxDataA), 32'h11);
        ackRx(0);
`endif
        checkOutput("ovr empty after acks", 32'(availA), 32'd0);
        checkOutput("ovr cleared by ack", 32'(ovrA), 32'd0);

        // One-tick glitch on an idle line
        rxdA = 1'b0;
        repeat (2) @(negedge clk);
        rxdA = 1'b1;
        repeat (640) @(negedge clk);
        checkOutput("glitch avail", 32'(availA), 32'd0);
        checkOutput("glitch frame_err", 32'(ferrA), 32'd0);
        checkOutput("glitch overrun", 32'(ovrA), 32'd0);

        // Break: line held low for two frame times and beyond
        rxdA = 1'b0;
        repeat (640) @(negedge clk);
        checkOutput("break frame_err", 32'(ferrA), 32'd1);
        checkOutput("break avail", 32'(availA), 32'd0);
        repeat (320) @(negedge clk);
        checkOutput("break still no word", 32'(availA), 32'd0);
        rxdA = 1'b1;
        repeat (64) @(negedge clk);
        applyStimulus(0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (4) @(negedge clk);
        checkOutput("after break avail", 32'(availA), 32'd1);
        checkOutput("after break data", 32'(rxDataA), 32'h5A);
        checkOutput("frame_err sticky", 32'(ferrA), 32'd1);
        ackRx(0);
        checkOutput("frame_err cleared", 32'(ferrA), 32'd0);

        // 8O1: 0x3C with a wrong parity bit, then 0xA7 with the right one
        applyStimulus(1, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        repeat (4) @(negedge clk);
        checkOutput("rxC avail", 32'(availC), 32'd1);
        checkOutput("rxC data", 32'(rxDataC), 32'h3C);
        checkOutput("rxC parity_err bad", 32'(perrC), 32'd1);
        checkOutput("rxC frame_err", 32'(ferrC), 32'd0);
        ackRx(2);
        applyStimulus(1, {1'b0, 1'b1, 1'b0, 8'hA7, 1'b0}, 11);
        repeat (4) @(negedge clk);
        checkOutput("rxC data good", 32'(rxDataC), 32'hA7);
        checkOutput("rxC parity_err good", 32'(perrC), 32'd0);

        // 7E2 loopback of 0x55
        txDataB = 7'h55;
        wrB = 1'b1;
        @(negedge clk);
        wrB = 1'b0;
        captureTx(1, n);
        checkOutput("txB frame done", 32'(busyB), 32'd0);
        checkOutput("txB busy length", n, clampTo(n, 352, 354));
        expBits = {1'b0, 2'b11, 1'b0, 7'h55, 1'b0};
        checkFrame("txB", n, expBits, 11);
        checkOutput("loop avail", 32'(availB), 32'd1);
        checkOutput("loop data", 32'(rxDataB), 32'h55);
        checkOutput("loop parity_err", 32'(perrB), 32'd0);
        checkOutput("loop frame_err", 32'(ferrB), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
